// File: rtl/truth_table_sweeper_if.sv
// Bundle of the sweeper's control handshake, result bus and the four-input
// stimulus/response link to the combinational circuit under test.
interface truth_table_sweeper_if;
    logic        start;
    logic [15:0] expected;
    logic        f_in;
    logic        x;
    logic        y;
    logic        w;
    logic        z;
    logic        busy;
    logic        done;
    logic [15:0] truth_table;
    logic        mismatch;
    logic [4:0]  fail_count;
    logic [3:0]  first_fail_idx;

    // Sweeper side: takes the start request, expected table and f, drives the rest
    modport slave (
        input  start,
        input  expected,
        input  f_in,
        output x,
        output y,
        output w,
        output z,
        output busy,
        output done,
        output truth_table,
        output mismatch,
        output fail_count,
        output first_fail_idx
    );

    // Controller side: issues sweeps and observes the results
    modport master (
        output start,
        output expected,
        output f_in,
        input  x,
        input  y,
        input  w,
        input  z,
        input  busy,
        input  done,
        input  truth_table,
        input  mismatch,
        input  fail_count,
        input  first_fail_idx
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// Walks a 4-input combinational circuit through all 16 input combinations
// (x is the slowest bit, z the fastest), samples f after SETTLE cycles per
// vector, builds the truth table and compares it with a captured expected table.
module truth_table_sweeper #(
    parameter int SETTLE       = 1,
    parameter bit STOP_ON_FAIL = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    truth_table_sweeper_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        FINISH
    } state_t;

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    state_t      state;
    state_t      state_next;
    logic [3:0]  idx;
    logic [3:0]  cnt;
    logic [15:0] exp_q;
    logic [15:0] table_q;
    logic [4:0]  fail_q;
    logic [3:0]  first_q;
    logic        mismatch_q;

    logic        sample_now;
    logic        cur_miss;
    logic        last_vec;
    logic        busy_c;
    logic        done_c;

    // Next-state and Moore outputs; the sample strobe marks the last cycle of a vector
    always_comb begin
        state_next = state;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        sample_now = (state == APPLY) && (cnt == SETTLE_CNT);
        cur_miss   = sample_now && (bus.f_in != exp_q[idx]);
        last_vec   = (idx == 4'hF) || (STOP_ON_FAIL && cur_miss);
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = APPLY;
                end
            end
            APPLY: begin
                busy_c = 1'b1;
                if (sample_now && last_vec) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                done_c     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Vector index, settle counter and result accumulation
    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= 4'd0;
            cnt        <= 4'd0;
            exp_q      <= 16'd0;
            table_q    <= 16'd0;
            fail_q     <= 5'd0;
            first_q    <= 4'd0;
            mismatch_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        exp_q      <= bus.expected;
                        table_q    <= 16'd0;
                        fail_q     <= 5'd0;
                        first_q    <= 4'd0;
                        mismatch_q <= 1'b0;
                        idx        <= 4'd0;
                        cnt        <= 4'd0;
                    end
                end
                APPLY: begin
                    if (sample_now) begin
                        table_q[idx] <= bus.f_in;
                        if (cur_miss) begin
                            fail_q <= fail_q + 5'd1;
                            if (!mismatch_q) begin
                                first_q    <= idx;
                                mismatch_q <= 1'b1;
                            end
                        end
                        if (!last_vec) begin
                            idx <= idx + 4'd1;
                            cnt <= 4'd0;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // The index register itself drives the circuit under test, so it holds in IDLE
    assign bus.x              = idx[3];
    assign bus.y              = idx[2];
    assign bus.w              = idx[1];
    assign bus.z              = idx[0];
    assign bus.busy           = busy_c;
    assign bus.done           = done_c;
    assign bus.truth_table    = table_q;
    assign bus.mismatch       = mismatch_q;
    assign bus.fail_count     = fail_q;
    assign bus.first_fail_idx = first_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: three instances (SETTLE=1 free-running,
// SETTLE=1 stop-on-fail, SETTLE=3 free-running) share one stimulus process;
// expected sweep results go into a scoreboard queue that a negedge monitor
// pops on every done pulse.
module tb_truth_table_sweeper;

    typedef struct {
        int          unit;
        logic [15:0] tt;
        logic        mm;
        logic [4:0]  fc;
        logic [3:0]  ffi;
        int          cycles;
    } result_t;

    logic clk = 1'b0;
    logic rst;
    logic [2:0]       start_v;
    logic [15:0]      exp_v;
    logic [1:0]       f_mode;
    logic [2:0]       busy_v;
    logic [2:0]       done_v;
    logic [2:0]       mm_v;
    logic [2:0][3:0]  vec_v;
    logic [2:0][15:0] tt_v;
    logic [2:0][4:0]  fc_v;
    logic [2:0][3:0]  ffi_v;

    result_t sb[$];
    result_t e;
    int checks    = 0;
    int failures  = 0;
    int done_cnt  = 0;
    int busy_cnt  = 0;
    int order_err = 0;
    logic busy_in_reset = 1'b0;

    // Free-running clock, 10 time-unit period
    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : unit
            truth_table_sweeper_if bus();
            assign bus.start    = start_v[g];
            assign bus.expected = exp_v;
            assign bus.f_in     = (f_mode == 2'd0) ? bus.z :
                                  (f_mode == 2'd1) ? (bus.x & bus.y) : 1'b0;
            assign busy_v[g] = bus.busy;
            assign done_v[g] = bus.done;
            assign mm_v[g]   = bus.mismatch;
            assign vec_v[g]  = {bus.x, bus.y, bus.w, bus.z};
            assign tt_v[g]   = bus.truth_table;
            assign fc_v[g]   = bus.fail_count;
            assign ffi_v[g]  = bus.first_fail_idx;
            truth_table_sweeper #(
                .SETTLE(g == 2 ? 3 : 1),
                .STOP_ON_FAIL(g == 1)
            ) dut (
                .clk(clk),
                .rst(rst),
                .bus(bus)
            );
        end
    endgenerate

    function automatic int settleOf(input int u);
        return (u == 2) ? 3 : 1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, req);
        end
    endtask

    // Monitor: tracks vector order and busy length, checks results on each done
    always @(negedge clk) begin
        if (rst) begin
            busy_cnt  = 0;
            order_err = 0;
            if (busy_v != 3'b000) busy_in_reset = 1'b1;
        end else begin
            for (int u = 0; u < 3; u++) begin
                if (busy_v[u]) begin
                    if (vec_v[u] != 4'(busy_cnt / (settleOf(u) + 1))) order_err++;
                    busy_cnt++;
                end
                if (done_v[u]) begin
                    done_cnt++;
                    if (sb.size() == 0) begin
                        checkOutput("unexpected_done", 32'(done_v[u]), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("done_unit", u, e.unit);
                        checkOutput("truth_table", 32'(tt_v[u]), 32'(e.tt));
                        checkOutput("mismatch", 32'(mm_v[u]), 32'(e.mm));
                        checkOutput("fail_count", 32'(fc_v[u]), 32'(e.fc));
                        checkOutput("first_fail_idx", 32'(ffi_v[u]), 32'(e.ffi));
                        checkOutput("busy_cycles", busy_cnt, e.cycles);
                        checkOutput("vector_order_errors", order_err, 0);
                        checkOutput("busy_low_at_done", 32'(busy_v[u]), 32'd0);
                    end
                    busy_cnt  = 0;
                    order_err = 0;
                end
            end
        end
    end

    task automatic pushExpect(input int u, input logic [15:0] tt, input logic mm,
                              input logic [4:0] fc, input logic [3:0] ffi, input int cycles);
        result_t r;
        r.unit = u; r.tt = tt; r.mm = mm; r.fc = fc; r.ffi = ffi; r.cycles = cycles;
        sb.push_back(r);
    endtask

    task automatic pulseStart(input int u);
        start_v[u] = 1'b1;
        @(negedge clk);
        start_v[u] = 1'b0;
    endtask

    task automatic waitDone(input int target);
        int n = 0;
        while (done_cnt < target && n < 300) begin
            @(negedge clk); #1;
            n++;
        end
        checkOutput("done_seen", 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic waitVec(input int u, input logic [3:0] v);
        int n = 0;
        logic found = 1'b0;
        while (!found && n < 300) begin
            @(negedge clk); #1;
            found = busy_v[u] && (vec_v[u] == v);
            n++;
        end
        checkOutput("reach_vec", 32'(found), 32'd1);
    endtask

    task automatic applyStimulus(input int u, input logic [1:0] mode, input logic [15:0] exp_tab,
                                 input logic [15:0] tt, input logic mm, input logic [4:0] fc,
                                 input logic [3:0] ffi, input int cycles);
        int target;
        target = done_cnt + 1;
        pushExpect(u, tt, mm, fc, ffi, cycles);
        f_mode = mode;
        exp_v  = exp_tab;
        pulseStart(u);
        waitDone(target);
        repeat (3) @(negedge clk);
    endtask

    task automatic checkCleared(input string tag, input int u);
        checkOutput({tag, "_busy"}, 32'(busy_v[u]), 32'd0);
        checkOutput({tag, "_done"}, 32'(done_v[u]), 32'd0);
        checkOutput({tag, "_table"}, 32'(tt_v[u]), 32'd0);
        checkOutput({tag, "_mismatch"}, 32'(mm_v[u]), 32'd0);
        checkOutput({tag, "_fails"}, 32'(fc_v[u]), 32'd0);
        checkOutput({tag, "_first"}, 32'(ffi_v[u]), 32'd0);
        checkOutput({tag, "_vector"}, 32'(vec_v[u]), 32'd0);
    endtask

    // Directed stimulus sequence
    initial begin
        int target;
        rst     = 1'b1;
        start_v = 3'b111;
        exp_v   = 16'hFFFF;
        f_mode  = 2'd0;
        repeat (4) @(negedge clk);
        #1;
        checkCleared("reset", 0);
        checkCleared("reset_stop", 1);
        start_v = 3'b000;
        rst     = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        checkOutput("idle_after_reset", 32'(busy_v), 32'd0);

        $display("[TB] full sweeps, SETTLE=1");
        applyStimulus(0, 2'd0, 16'hAAAA, 16'hAAAA, 1'b0, 5'd0, 4'd0, 32);
        applyStimulus(0, 2'd1, 16'hF000, 16'hF000, 1'b0, 5'd0, 4'd0, 32);
        applyStimulus(0, 2'd1, 16'hF001, 16'hF000, 1'b1, 5'd1, 4'd0, 32);
        applyStimulus(0, 2'd1, 16'h7000, 16'hF000, 1'b1, 5'd1, 4'hF, 32);
        applyStimulus(0, 2'd2, 16'hFFFF, 16'h0000, 1'b1, 5'd16, 4'd0, 32);

        $display("[TB] stop-on-fail sweeps");
        applyStimulus(1, 2'd2, 16'hFFFF, 16'h0000, 1'b1, 5'd1, 4'd0, 2);
        applyStimulus(1, 2'd1, 16'h0000, 16'h1000, 1'b1, 5'd1, 4'hC, 26);
        applyStimulus(1, 2'd0, 16'hAAAA, 16'hAAAA, 1'b0, 5'd0, 4'd0, 32);

        $display("[TB] reset during sweep");
        f_mode = 2'd0;
        exp_v  = 16'hAAAA;
        pulseStart(0);
        waitVec(0, 4'd7);
        rst = 1'b1;
        @(negedge clk); #1;
        checkCleared("abort", 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        applyStimulus(0, 2'd0, 16'hAAAA, 16'hAAAA, 1'b0, 5'd0, 4'd0, 32);

        $display("[TB] start held high, back-to-back sweeps");
        target = done_cnt + 1;
        pushExpect(0, 16'hF000, 1'b0, 5'd0, 4'd0, 32);
        pushExpect(0, 16'hF000, 1'b0, 5'd0, 4'd0, 32);
        f_mode     = 2'd1;
        exp_v      = 16'hF000;
        start_v[0] = 1'b1;
        waitDone(target);
        @(negedge clk); #1;
        checkOutput("b2b_idle_gap", 32'(busy_v[0]), 32'd0);
        @(negedge clk); #1;
        checkOutput("b2b_restart", 32'(busy_v[0]), 32'd1);
        start_v[0] = 1'b0;
        waitDone(target + 1);
        repeat (3) @(negedge clk);

        $display("[TB] start re-pulse and expected change mid-sweep, SETTLE=3");
        target = done_cnt + 1;
        pushExpect(2, 16'hAAAA, 1'b0, 5'd0, 4'd0, 64);
        f_mode = 2'd0;
        exp_v  = 16'hAAAA;
        pulseStart(2);
        waitVec(2, 4'd5);
        exp_v = 16'h0000;
        pulseStart(2);
        waitDone(target);
        repeat (10) @(negedge clk);

        checkOutput("scoreboard_empty", sb.size(), 0);
        checkOutput("busy_in_reset", 32'(busy_in_reset), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
Sequencer that drives a 4-input combinational unit-under-test (inputs x, y, w, z; output f) through all 16 input combinations in a fixed order. It samples f after a programmable settle time and builds a 16-bit truth table. It compares that table against an expected table and reports pass/fail, mismatch count and the first failing index. It replaces hand-written nested-loop stimulus with a reusable, clocked, start/done-controlled block placed beside the combinational circuit.

Parameters:
SETTLE, 1, cycles between applying a vector and sampling f (legal range 1..15)
STOP_ON_FAIL, 0, 1 = end the sweep at the first mismatch; 0 = always sweep all 16 vectors

Ports:
clk  input  1  single clock, all state changes on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begin a sweep; sampled only in IDLE
expected  input  16  expected truth table; bit i = expected f for index i; captured on accepted start
f_in  input  1  output f of the circuit under test
x  output  1  UUT input, index bit 3 (MSB)
y  output  1  UUT input, index bit 2
w  output  1  UUT input, index bit 1
z  output  1  UUT input, index bit 0 (LSB)
busy  output  1  high while a sweep is in progress
done  output  1  one-cycle pulse when a sweep ends
truth_table  output  16  captured f values; bit i = f sampled at index i
mismatch  output  1  valid from done onward: 1 if any compared bit differs
fail_count  output  5  number of mismatching indices (0..16)
first_fail_idx  output  4  lowest mismatching index; 0 when mismatch=0

Behaviour:
- Reset (synchronous, rst=1 at clock edge): state=IDLE; x,y,w,z=0; busy=0; done=0; truth_table=0; mismatch=0; fail_count=0; first_fail_idx=0; internal idx and settle counter=0. Reset overrides start. Reset mid-sweep aborts immediately with no done pulse.
- Index order: idx runs from 0 to 15. {x,y,w,z}=idx, so x is the outermost (slowest) bit and z the fastest.
- States: IDLE, APPLY, FINISH.
- IDLE: busy=0. When start=1, the block:
  - captures expected;
  - clears truth_table, fail_count, mismatch and first_fail_idx;
  - sets idx=0 and cnt=0;
  - goes to APPLY.
  x,y,w,z hold their last values while in IDLE.
- APPLY: busy=1 and {x,y,w,z}=idx.
  - cnt increments each cycle.
  - On the cycle with cnt==SETTLE, the block samples f_in into truth_table[idx] and compares it with expected[idx].
  - On a mismatch it increments fail_count. If this is the first mismatch, it sets first_fail_idx=idx and mismatch=1.
  - Each vector therefore occupies SETTLE+1 cycles.
- After the sample cycle:
  - if idx==15, or (STOP_ON_FAIL=1 and the current sample mismatched), go to FINISH;
  - else idx increments, cnt=0, and the block stays in APPLY.
- FINISH: busy=0 and done=1 for exactly one cycle, then IDLE. Results hold until the next accepted start or reset.
- start asserted while busy or in FINISH is ignored; no queuing.
- start held high continuously causes back-to-back sweeps, with one IDLE cycle between FINISH and the next APPLY.
- idx never wraps within a sweep. fail_count saturates naturally at 16 (5 bits). With STOP_ON_FAIL=1, truth_table bits above the failing index remain 0.
- expected changes during a sweep have no effect (the captured copy is used).
- Latency, full sweep with accepted start at edge 0:
  - APPLY spans edges 1 .. 16*(SETTLE+1);
  - done is high in the cycle after the last sample;
  - with SETTLE=1, busy is high for 32 cycles and done is high in cycle 33.

Test Plan:
- Reset check: hold rst=1 with start=1 → all outputs 0, busy never rises; release rst → block stays in IDLE until start.
- f_in tied to z, expected=16'hAAAA, SETTLE=1, start pulse → x,y,w,z step 0000..1111 every 2 cycles; busy high 32 cycles; done pulse in cycle 33; truth_table=16'hAAAA, mismatch=0, fail_count=0, first_fail_idx=0.
- f_in = x & y (UUT combinational), expected=16'hF000 → truth_table=16'hF000, mismatch=0. Rerun with expected=16'hF001 → mismatch=1, fail_count=1, first_fail_idx=0.
- f_in tied 0, expected=16'hFFFF, STOP_ON_FAIL=1 → sweep ends after index 0; done in cycle 3 (SETTLE=1); truth_table=0, fail_count=1, first_fail_idx=0. Same stimulus with STOP_ON_FAIL=0 → fail_count=16, truth_table=0.
- Assert rst during APPLY at idx=7 → next cycle: IDLE, outputs 0, no done pulse. A new start produces a clean full sweep.
- start re-pulsed while busy at idx=5 → ignored: idx continues from 6, exactly one done pulse. With SETTLE=3, each vector holds 4 cycles; total busy=64 cycles.
